bcd_field_counter: RTL and testbench

BCD_FIELD_COUNTER -- requirements
Module: bcd_field_counter

---
 rtl/bcd_field_counter_pkg.sv | 22 ++
 rtl/bcd_field_counter_digit.sv | 48 ++++
 rtl/bcd_field_counter.sv | 100 ++++++++++
 tb/tb_bcd_field_counter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_field_counter_pkg.sv
// Shared constants and helpers for two-digit BCD counting fields.
package bcd_field_counter_pkg;

   localparam int unsigned BCD_DIGIT_W       = 4;
   localparam int unsigned BCD_DIGIT_MAX     = 9;
   localparam int unsigned SEC_MIN_MAX_VALUE = 59;
   localparam int unsigned HOURS_MAX_VALUE   = 23;

   typedef struct packed {
      logic [BCD_DIGIT_W-1:0] tens;
      logic [BCD_DIGIT_W-1:0] ones;
   } bcd_pair_t;

   // Split a 0..99 value into its tens/ones digits.
   function automatic bcd_pair_t to_bcd_pair(input int unsigned value);
      bcd_pair_t r;
      r.tens = BCD_DIGIT_W'(value / 10);
      r.ones = BCD_DIGIT_W'(value % 10);
      return r;
   endfunction

endpackage

// File: rtl/bcd_field_counter_digit.sv
// Single mod-10 up/down BCD digit with load, programmable wrap limit and terminal count.
module bcd_digit
   import bcd_field_counter_pkg::*;
#(
   parameter logic [3:0] RESET_DIGIT = 4'd0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_en,
   input  logic                   i_dec,
   input  logic [BCD_DIGIT_W-1:0] i_limit,
   input  logic [BCD_DIGIT_W-1:0] i_wrap_val,
   input  logic                   i_ld,
   input  logic [BCD_DIGIT_W-1:0] i_ld_val,
   output logic [BCD_DIGIT_W-1:0] o_digit,
   output logic                   o_tc
);

   logic [BCD_DIGIT_W-1:0] r_digit;
   logic [BCD_DIGIT_W-1:0] w_next;

   // Terminal count: at the up limit when counting up, at zero when counting down.
   assign o_tc = i_dec ? (r_digit == '0) : (r_digit == i_limit);

   always_comb begin
      w_next = r_digit;
      if (i_ld) begin
         w_next = i_ld_val;
      end else if (i_en) begin
         if (i_dec) begin
            w_next = o_tc ? i_wrap_val : r_digit - BCD_DIGIT_W'(1);
         end else begin
            w_next = o_tc ? '0 : r_digit + BCD_DIGIT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_digit <= RESET_DIGIT;
      end else begin
         r_digit <= w_next;
      end
   end

   assign o_digit = r_digit;

endmodule

// File: rtl/bcd_field_counter.sv
// Two-digit BCD field (e.g. seconds/minutes/hours) with load, up/down count and cascade pulses.
module bcd_field_counter
   import bcd_field_counter_pkg::*;
#(
   parameter int unsigned MAX_VALUE   = SEC_MIN_MAX_VALUE,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       dec,
   input  logic       ld,
   input  logic [3:0] ld_tens,
   input  logic [3:0] ld_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry,
   output logic       borrow,
   output logic       ld_err
);

   if (MAX_VALUE < 1 || MAX_VALUE > 99) begin : g_bad_max_value
      $error("bcd_field_counter: MAX_VALUE must be in 1..99");
   end
   if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset_value
      $error("bcd_field_counter: RESET_VALUE must not exceed MAX_VALUE");
   end

   localparam bcd_pair_t MAX_BCD   = to_bcd_pair(MAX_VALUE);
   localparam bcd_pair_t RESET_BCD = to_bcd_pair(RESET_VALUE);

   logic       w_step;
   logic       w_ones_tc;
   logic       w_tens_tc;
   logic       w_tens_en;
   logic       w_field_tc;
   logic       w_ld_ok;
   logic       w_ld_apply;
   logic [7:0] w_ld_value;
   logic [3:0] w_ones_limit;
   logic [3:0] w_ones_wrap_val;
   logic       r_ld_err;

   assign w_ld_value = 8'(ld_tens) * 8'd10 + 8'(ld_ones);
   assign w_ld_ok    = (ld_tens <= 4'(BCD_DIGIT_MAX)) && (ld_ones <= 4'(BCD_DIGIT_MAX))
                       && (w_ld_value <= 8'(MAX_VALUE));
   assign w_ld_apply = ld & w_ld_ok;
   assign w_step     = en & ~ld;

   // Tens terminal count selects the short ones range in the top decade / bottom wrap.
   assign w_ones_limit    = w_tens_tc ? MAX_BCD.ones : 4'(BCD_DIGIT_MAX);
   assign w_ones_wrap_val = w_tens_tc ? MAX_BCD.ones : 4'(BCD_DIGIT_MAX);
   assign w_tens_en       = w_step & w_ones_tc;
   assign w_field_tc      = w_ones_tc & w_tens_tc;

   bcd_digit #(
      .RESET_DIGIT (RESET_BCD.ones)
   ) u_ones (
      .clk        (clk),
      .reset      (reset),
      .i_en       (w_step),
      .i_dec      (dec),
      .i_limit    (w_ones_limit),
      .i_wrap_val (w_ones_wrap_val),
      .i_ld       (w_ld_apply),
      .i_ld_val   (ld_ones),
      .o_digit    (ones),
      .o_tc       (w_ones_tc)
   );

   bcd_digit #(
      .RESET_DIGIT (RESET_BCD.tens)
   ) u_tens (
      .clk        (clk),
      .reset      (reset),
      .i_en       (w_tens_en),
      .i_dec      (dec),
      .i_limit    (MAX_BCD.tens),
      .i_wrap_val (MAX_BCD.tens),
      .i_ld       (w_ld_apply),
      .i_ld_val   (ld_tens),
      .o_digit    (tens),
      .o_tc       (w_tens_tc)
   );

   // Zero-latency cascade pulses, forced low during reset.
   assign carry  = ~reset & w_step & ~dec & w_field_tc;
   assign borrow = ~reset & w_step &  dec & w_field_tc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ld_err <= 1'b0;
      end else begin
         r_ld_err <= ld & ~w_ld_ok;
      end
   end

   assign ld_err = r_ld_err;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Scoreboard bench: seconds->minutes cascade plus an hours field, checked against an integer model.
module tb_bcd_field_counter;
   import bcd_field_counter_pkg::*;

   localparam int HR_RESET = 12;

   typedef struct packed {
      logic [2:0][6:0] v;
      logic [2:0]      err;
      logic [2:0]      c;
      logic [2:0]      b;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en, dec, ld, min_ld;
   logic [3:0] ld_tens, ld_ones, min_ld_tens, min_ld_ones;
   logic [3:0] tens_a [3];
   logic [3:0] ones_a [3];
   logic       carry_a [3];
   logic       borrow_a [3];
   logic       ld_err_a [3];

   int   max_v [3] = '{59, 59, 23};
   int   rst_v [3] = '{0, 0, HR_RESET};
   int   m_v   [3];
   exp_t exp_q [$];
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   bcd_field_counter #(.MAX_VALUE(SEC_MIN_MAX_VALUE), .RESET_VALUE(0)) u_sec (
      .clk(clk), .reset(reset), .en(en), .dec(dec), .ld(ld),
      .ld_tens(ld_tens), .ld_ones(ld_ones), .tens(tens_a[0]), .ones(ones_a[0]),
      .carry(carry_a[0]), .borrow(borrow_a[0]), .ld_err(ld_err_a[0]));

   bcd_field_counter #(.MAX_VALUE(SEC_MIN_MAX_VALUE), .RESET_VALUE(0)) u_min (
      .clk(clk), .reset(reset), .en(carry_a[0]), .dec(dec), .ld(min_ld),
      .ld_tens(min_ld_tens), .ld_ones(min_ld_ones), .tens(tens_a[1]), .ones(ones_a[1]),
      .carry(carry_a[1]), .borrow(borrow_a[1]), .ld_err(ld_err_a[1]));

   bcd_field_counter #(.MAX_VALUE(HOURS_MAX_VALUE), .RESET_VALUE(HR_RESET)) u_hr (
      .clk(clk), .reset(reset), .en(en), .dec(dec), .ld(ld),
      .ld_tens(ld_tens), .ld_ones(ld_ones), .tens(tens_a[2]), .ones(ones_a[2]),
      .carry(carry_a[2]), .borrow(borrow_a[2]), .ld_err(ld_err_a[2]));

   function automatic void check(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
   endfunction

   function automatic int bcd_of(input int v);
      logic [7:0] r;
      r = {4'(v / 10), 4'(v % 10)};
      return int'(r);
   endfunction

   // Field behaviour expressed on the integer value V.
   function automatic void step_model(input int v, input int mx, input bit e, input bit d,
                                      input bit l, input int lt, input int lo,
                                      output int nv, output bit err, output bit c, output bit b);
      c   = e && !l && !d && (v == mx);
      b   = e && !l && d && (v == 0);
      err = 1'b0;
      nv  = v;
      if (l) begin
         if (lt <= 9 && lo <= 9 && lt * 10 + lo <= mx) nv = lt * 10 + lo;
         else err = 1'b1;
      end else if (e) begin
         if (!d) nv = (v == mx) ? 0 : v + 1;
         else    nv = (v == 0) ? mx : v - 1;
      end
   endfunction

   task automatic cycle(input bit i_en, input bit i_dec, input bit i_ld, input int lt,
                        input int lo, input bit i_mld, input int mlt, input int mlo);
      exp_t x;
      int   nv;
      bit   er, c, b, sec_c;
      @(negedge clk);
      reset = 1'b0;
      en = i_en; dec = i_dec; ld = i_ld;
      ld_tens = 4'(lt); ld_ones = 4'(lo);
      min_ld = i_mld; min_ld_tens = 4'(mlt); min_ld_ones = 4'(mlo);
      step_model(m_v[0], max_v[0], i_en, i_dec, i_ld, lt, lo, nv, er, c, b);
      x.v[0] = 7'(nv); x.err[0] = er; x.c[0] = c; x.b[0] = b; m_v[0] = nv; sec_c = c;
      step_model(m_v[1], max_v[1], sec_c, i_dec, i_mld, mlt, mlo, nv, er, c, b);
      x.v[1] = 7'(nv); x.err[1] = er; x.c[1] = c; x.b[1] = b; m_v[1] = nv;
      step_model(m_v[2], max_v[2], i_en, i_dec, i_ld, lt, lo, nv, er, c, b);
      x.v[2] = 7'(nv); x.err[2] = er; x.c[2] = c; x.b[2] = b; m_v[2] = nv;
      exp_q.push_back(x);
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_val%0d", tag, i), bcd_of(int'({tens_a[i], ones_a[i]}) / 16 * 10
               + int'(ones_a[i])) , bcd_of(rst_v[i]));
         check($sformatf("%s_lderr%0d", tag, i), int'(ld_err_a[i]), 0);
         check($sformatf("%s_carry%0d", tag, i), int'(carry_a[i]), 0);
         check($sformatf("%s_borrow%0d", tag, i), int'(borrow_a[i]), 0);
         m_v[i] = rst_v[i];
      end
   endtask

   // Reset asserted between edges with a count request pending.
   task automatic reset_window();
      @(negedge clk);
      en = 1'b1; dec = 1'b1; ld = 1'b0; min_ld = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_state("async_rst");
      @(posedge clk);
   endtask

   // Monitor: comb pulses sampled before the edge, registered state after it.
   initial begin
      exp_t x;
      bit   cs_c [3];
      bit   cs_b [3];
      forever begin
         @(negedge clk);
         #2;
         for (int i = 0; i < 3; i++) begin
            cs_c[i] = carry_a[i];
            cs_b[i] = borrow_a[i];
         end
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            for (int i = 0; i < 3; i++) begin
               check($sformatf("val%0d", i), int'({tens_a[i], ones_a[i]}), bcd_of(int'(x.v[i])));
               check($sformatf("lderr%0d", i), int'(ld_err_a[i]), int'(x.err[i]));
               check($sformatf("carry%0d", i), int'(cs_c[i]), int'(x.c[i]));
               check($sformatf("borrow%0d", i), int'(cs_b[i]), int'(x.b[i]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit rdec;
      en = 1'b0; dec = 1'b0; ld = 1'b0; min_ld = 1'b0;
      ld_tens = '0; ld_ones = '0; min_ld_tens = '0; min_ld_ones = '0;
      #1 reset = 1'b1;
      #12 check_reset_state("por");

      repeat (60) cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);

      cycle(0, 0, 1, 0, 0, 1, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0, 0);
      cycle(1, 1, 0, 0, 0, 0, 0, 0);

      cycle(0, 0, 1, 2, 4, 0, 0, 0);
      cycle(0, 0, 1, 1, 9, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0, 0, 0);

      cycle(0, 0, 1, 5, 9, 0, 0, 0);
      cycle(1, 0, 1, 3, 0, 0, 0, 0);

      cycle(0, 0, 1, 5, 9, 1, 5, 9);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);

      cycle(0, 0, 1, 10, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 12, 1, 6, 0);
      cycle(0, 0, 1, 9, 9, 1, 15, 15);

      reset_window();
      repeat (5) cycle(1, 0, 0, 0, 0, 0, 0, 0);
      reset_window();
      cycle(1, 1, 0, 0, 0, 0, 0, 0);

      rdec = 1'b0;
      for (int n = 0; n < 500; n++) begin
         bit r_en, r_ld, r_mld;
         int lt, lo;
         if ($urandom_range(0, 15) == 0) rdec = ~rdec;
         r_en  = ($urandom_range(0, 3) != 0);
         r_ld  = ($urandom_range(0, 9) == 0);
         r_mld = ($urandom_range(0, 19) == 0);
         lt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 5));
         lo = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
         cycle(r_en, rdec, r_ld, lt, lo, r_mld, int'($urandom_range(0, 6)), int'($urandom_range(0, 9)));
      end

      reset_window();
      cycle(1, 0, 1, 0, 7, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);

      @(posedge clk);
      #3;
      check("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
